// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory stage (master) and the data-memory responder (slave).
// Signal names follow the pipeline's existing data-memory bus.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_bytemask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] txn_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_bytemask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, txn_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_bytemask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, txn_count
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// commits on the edge entering RESP and holds the response until the requester takes it.
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                 CLK,
    input  logic                 resetl,
    data_mem_responder_if.slave  bus
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t r_state, w_state_nxt;

    logic [3:0]  r_cnt;
    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_mask;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [31:0] r_txn;
    logic [63:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_commit;
    logic        w_done;
    logic        w_req_ready;
    logic        w_rsp_valid;

    // With LATENCY=0 the commit happens on the accept edge itself, so the
    // commit path must see the live request rather than the latched copy.
    logic        w_sel_write;
    logic [63:0] w_sel_addr;
    logic [63:0] w_sel_wdata;
    logic [7:0]  w_sel_mask;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_sel_write = (r_state == IDLE) ? bus.req_write    : r_write;
    assign w_sel_addr  = (r_state == IDLE) ? bus.req_addr     : r_addr;
    assign w_sel_wdata = (r_state == IDLE) ? bus.req_wdata    : r_wdata;
    assign w_sel_mask  = (r_state == IDLE) ? bus.req_bytemask : r_mask;

    assign w_misalign = (w_sel_addr[2:0] != 3'd0);
    assign w_oor      = |w_sel_addr[63:DEPTH_LOG2+3];
    assign w_err      = w_misalign | w_oor;
    assign w_idx      = w_sel_addr[DEPTH_LOG2+2:3];

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_done      = 1'b0;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_mask  <= 8'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
            r_txn   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LAT_M1;
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_mask  <= bus.req_bytemask;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_commit) begin
                r_rdata <= (w_err || w_sel_write) ? 64'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end else if (w_done) begin
                r_rdata <= 64'd0;
                r_err   <= 1'b0;
                r_txn   <= r_txn + 32'd1;
            end
        end
    end

    // Storage is deliberately not reset; the resetl gate keeps a LATENCY=0
    // request presented during reset from slipping a write through.
    always_ff @(posedge CLK) begin
        if (resetl && w_commit && w_sel_write && !w_err) begin
            for (int b = 0; b < 8; b++) begin
                if (w_sel_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.txn_count = r_txn;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the data-memory request/response interface driven by the pipeline's memory stage.
- Holds DEPTH doublewords of storage and accepts one LDUR/STUR-style request at a time through a valid/ready handshake.
- Inserts a programmable number of wait cycles, then returns read data or a write acknowledge, with error flagging.
- Lets the pipeline be verified against a memory that does not answer in a single cycle.

Parameters:
- DEPTH_LOG2, 8, log2 of storage depth in 64-bit doublewords (default 256 entries).
- LATENCY, 2, wait cycles between the accept cycle and the response cycle; legal range 0..15.

Ports:
- CLK  input  1  clock, rising-edge.
- resetl  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- req_bytemask  input  8  store byte enables; bit i enables wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  64  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.
- txn_count  output  32  completed-transaction counter.

Behaviour:
- FSM states: IDLE, WAIT, RESP. On reset (resetl low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, txn_count = 0, wait counter = 0.
  - Storage contents are not cleared.
- IDLE:
  - req_ready = 1.
  - At an edge with req_valid=1, latch write, addr, wdata and bytemask.
  - If LATENCY=0, go to RESP; otherwise go to WAIT with counter = LATENCY-1.
  - With req_valid=0, stay in IDLE.
- WAIT:
  - req_ready = 0.
  - At each edge: if counter = 0, go to RESP; else decrement the counter.
- Entry to RESP:
  - The edge that enters RESP is the commit point; rsp_rdata and rsp_err register on that edge.
  - Store: write the enabled bytes; disabled bytes keep their old value.
  - Load: rsp_rdata = mem[index].
  - The response is visible exactly LATENCY cycles after the accept cycle.
- RESP:
  - rsp_valid = 1, req_ready = 0.
  - rsp_rdata and rsp_err are held stable until the handshake.
  - At an edge with rsp_ready=1: go to IDLE, drop rsp_valid, clear rsp_rdata and rsp_err, increment txn_count.
  - Error responses are also counted.
- Addressing:
  - index = req_addr[DEPTH_LOG2+2:3].
  - Misaligned if req_addr[2:0] != 0.
  - Out of range if any of req_addr[63:DEPTH_LOG2+3] != 0.
  - Either condition gives rsp_err=1, rsp_rdata=0, and no storage write.
- Throughput: no back-to-back requests; minimum period is LATENCY+2 cycles. Throughput is one request per handshake pair, so the next accept is possible in the cycle after the RESP handshake.
- req_valid held during WAIT/RESP is ignored; it is not accepted until IDLE.
- A store with bytemask = 0 is a legal no-op write: rsp_err=0, counted.
- txn_count wraps from 0xFFFFFFFF to 0.
- Reset mid-operation:
  - Reset in WAIT abandons the request; a store is not committed.
  - Reset in RESP drops the response; a store already committed stays written.
- Latched request fields are unaffected by input changes after accept.

Test Plan:
1. LATENCY=2: store addr 0x10, wdata 0x1122334455667788, mask 0xFF, rsp_ready=1.
   - Expect req_ready low for 3 cycles, rsp_valid 2 cycles after accept, rsp_err=0, txn_count=1.
   - A subsequent load of 0x10 returns 0x1122334455667788.
2. Partial store at 0x10: wdata 0xAAAAAAAAAAAAAAAA, mask 0x0F; then load 0x10.
   - Expect rdata 0x11223344AAAAAAAA.
3. Load addr 0x13 (misaligned) and load addr 0x800 (out of range for DEPTH_LOG2=8).
   - Both give rsp_err=1, rdata=0, no storage change, txn_count incremented each time.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
   - rsp_valid and rsp_rdata stay constant and req_ready stays 0.
   - A new req_valid is not accepted until the cycle after rsp_ready=1.
5. LATENCY=0: load 0x10.
   - rsp_valid is high in the cycle immediately after the accept cycle; 1 cycle later after rsp_ready, req_ready=1.
6. Reset in WAIT during a store to 0x20 (prior value 0x5).
   - All outputs return to reset values; a later load of 0x20 returns 0x5.
